// File: rtl/aes_decipher_core.sv
// Iterative AES inverse cipher (AES-128/192/256) built from one-cycle
// handshake stages, with round keys read from an external key memory.

package aes_inv_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x3;
        logic [7:0] x12;
        logic [7:0] x15;
        logic [7:0] x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
            gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
            gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
            gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
            gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

endpackage

module inv_shift_rows (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         valid_out
);
    logic [127:0] shifted;

    // Byte r+4c is row r, column c; row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(r+4*c) -: 8] =
                    data_in[127-8*(r+4*((c-r)&3)) -: 8];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= start;
            if (start) data_out <= shifted;
        end
    end
endmodule

module inv_sub_bytes (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         valid_out
);
    import aes_inv_pkg::*;

    logic [127:0] subbed;

    always_comb begin
        subbed = '0;
        for (int k = 0; k < 16; k++) begin
            subbed[127-8*k -: 8] = inv_sbox(data_in[127-8*k -: 8]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= start;
            if (start) data_out <= subbed;
        end
    end
endmodule

module add_round_key (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         valid_out
);
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= start;
            if (start) data_out <= data_in ^ key_in;
        end
    end
endmodule

module inv_mix_cols (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         valid_out
);
    import aes_inv_pkg::*;

    logic [127:0] mixed;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_col(data_in[127-32*c -: 32]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= start;
            if (start) data_out <= mixed;
        end
    end
endmodule

module aes_decipher_core #(
    parameter int NR          = 10,
    parameter int KEY_LATENCY = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic [127:0] block_in,
    output logic [3:0]   key_addr,
    input  logic [127:0] round_key_in,
    output logic         ready,
    output logic [127:0] block_out,
    output logic         block_complete,
    output logic [3:0]   round_idx
);
    generate
        if (!(NR == 10 || NR == 12 || NR == 14) ||
            KEY_LATENCY < 0 || KEY_LATENCY > 3) begin : g_bad_param
            $error("aes_decipher_core: illegal NR or KEY_LATENCY");
        end
    endgenerate

    localparam logic [3:0] NR4 = 4'(NR);
    localparam logic [1:0] KL2 = 2'(KEY_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        KEY_WAIT,
        INIT_ARK,
        ROUND,
        FINAL,
        OUTPUT
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         launch;
    logic         launch_nx;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   idx;
    logic [1:0]   lat_cnt;

    logic [127:0] isr_q;
    logic [127:0] isb_q;
    logic [127:0] ark_q;
    logic [127:0] imc_q;
    logic         isr_v;
    logic         isb_v;
    logic         ark_v;
    logic         imc_v;
    logic         imc_start;

    assign ready     = (state == IDLE);
    assign key_addr  = idx;
    assign round_idx = idx;
    // The final round skips the column mix entirely.
    assign imc_start = ark_v && (state == ROUND);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            launch <= 1'b0;
        end else begin
            state  <= state_nx;
            launch <= launch_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        launch_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    if (idx == NR4) begin
                        state_nx = INIT_ARK;
                    end else if (idx == 4'd0) begin
                        state_nx  = FINAL;
                        launch_nx = 1'b1;
                    end else begin
                        state_nx  = ROUND;
                        launch_nx = 1'b1;
                    end
                end
            end
            INIT_ARK: state_nx = KEY_WAIT;
            ROUND: begin
                if (imc_v) state_nx = KEY_WAIT;
            end
            FINAL: begin
                if (ark_v) state_nx = OUTPUT;
            end
            OUTPUT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= '0;
            key_reg        <= '0;
            idx            <= 4'd0;
            lat_cnt        <= 2'd0;
            block_out      <= '0;
            block_complete <= 1'b0;
        end else begin
            block_complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state_reg <= block_in;
                        idx       <= NR4;
                        lat_cnt   <= KL2;
                        block_out <= '0;
                    end
                end
                KEY_WAIT: begin
                    if (lat_cnt == 2'd0) key_reg <= round_key_in;
                    else lat_cnt <= lat_cnt - 2'd1;
                end
                INIT_ARK: begin
                    state_reg <= state_reg ^ key_reg;
                    idx       <= NR4 - 4'd1;
                    lat_cnt   <= KL2;
                end
                ROUND: begin
                    if (imc_v) begin
                        state_reg <= imc_q;
                        idx       <= idx - 4'd1;
                        lat_cnt   <= KL2;
                    end
                end
                FINAL: begin
                    if (ark_v) begin
                        block_out      <= ark_q;
                        block_complete <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    inv_shift_rows u_isr (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (launch),
        .data_in   (state_reg),
        .data_out  (isr_q),
        .valid_out (isr_v)
    );

    inv_sub_bytes u_isb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (isr_v),
        .data_in   (isr_q),
        .data_out  (isb_q),
        .valid_out (isb_v)
    );

    add_round_key u_ark (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (isb_v),
        .data_in   (isb_q),
        .key_in    (key_reg),
        .data_out  (ark_q),
        .valid_out (ark_v)
    );

    inv_mix_cols u_imc (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (imc_start),
        .data_in   (ark_q),
        .data_out  (imc_q),
        .valid_out (imc_v)
    );
endmodule

// File: tb/tb_aes_decipher_core.sv
// Directed bench for aes_decipher_core: FIPS-197 vectors over several
// NR / KEY_LATENCY configurations, plus busy-start, reset and back-to-back.

module tb_aes_decipher_core;

    localparam int N = 6;
    localparam int NR_T [N] = '{10, 10, 10, 10, 12, 14};
    localparam int KL_T [N] = '{1, 0, 2, 3, 1, 1};

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_v [N];
    logic [127:0] bin_v   [N];
    logic [3:0]   kaddr_w [N];
    logic [127:0] rkey_w  [N];
    logic         ready_w [N];
    logic [127:0] bo_w    [N];
    logic         bc_w    [N];
    logic [3:0]   ridx_w  [N];
    int           pulse_w [N];
    logic [127:0] rk [3][15];

    int checks = 0;
    int errors = 0;

    logic [3:0] kseq [$];
    logic [3:0] ka_prev = 4'd0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            logic [3:0] d1;
            logic [3:0] d2;
            logic [3:0] d3;
            logic [3:0] sel;
            int         pulses = 0;

            aes_decipher_core #(
                .NR          (NR_T[g]),
                .KEY_LATENCY (KL_T[g])
            ) u_dut (
                .clk_in         (clk),
                .rst_in         (rst),
                .start          (start_v[g]),
                .block_in       (bin_v[g]),
                .key_addr       (kaddr_w[g]),
                .round_key_in   (rkey_w[g]),
                .ready          (ready_w[g]),
                .block_out      (bo_w[g]),
                .block_complete (bc_w[g]),
                .round_idx      (ridx_w[g])
            );

            always @(posedge clk) begin
                d1 <= kaddr_w[g];
                d2 <= d1;
                d3 <= d2;
                if (bc_w[g] === 1'b1) pulses <= pulses + 1;
            end

            always_comb begin
                case (KL_T[g])
                    0:       sel = kaddr_w[g];
                    1:       sel = d1;
                    2:       sel = d2;
                    default: sel = d3;
                endcase
            end

            assign rkey_w[g]  = rk[(NR_T[g] - 10) / 2][sel];
            assign pulse_w[g] = pulses;
        end
    endgenerate

    always @(negedge clk) begin
        if (kaddr_w[0] !== ka_prev) begin
            kseq.push_back(kaddr_w[0]);
            ka_prev = kaddr_w[0];
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (mul(a, 8'(y)) == 8'h01) v = 8'(y);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
               {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input int t, input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = subword({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 15; r++) begin
            rk[t][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
        end
    endtask

    function automatic int lat_exp(input int nr, input int kl);
        return (nr + 1) * (kl + 1) + 1 + (nr - 1) * 5 + 4;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge
    // where block_complete is first seen high.
    task automatic run_block(input int i, input logic [127:0] blk,
                             input int poke, output logic [127:0] res,
                             output int lat, output logic [127:0] first_bo);
        start_v[i] = 1'b1;
        bin_v[i]   = blk;
        @(posedge clk);
        @(negedge clk);
        start_v[i] = 1'b0;
        first_bo   = bo_w[i];
        lat = 0;
        while (bc_w[i] !== 1'b1 && lat < 400) begin
            if (lat == poke) begin
                chk("busy_ready", 128'(ready_w[i]), 128'd0);
                start_v[i] = 1'b1;
                bin_v[i]   = ~blk;
            end else begin
                start_v[i] = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        chk("timeout", 128'(lat < 400), 128'd1);
        res = bo_w[i];
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] fbo;
        int           lat;
        int           p0;
        int           wait_n;
        int           lat_kl [4];

        for (int i = 0; i < N; i++) begin
            start_v[i] = 1'b0;
            bin_v[i]   = '0;
        end
        expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        expand(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(ready_w[0]), 128'd1);
        chk("rst_block_out", bo_w[0], 128'd0);
        chk("rst_complete", 128'(bc_w[0]), 128'd0);
        chk("rst_key_addr", 128'(kaddr_w[0]), 128'd0);
        chk("rst_round_idx", 128'(ridx_w[0]), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // start coincident with reset must be dropped
        rst        = 1'b1;
        start_v[0] = 1'b1;
        bin_v[0]   = CT128;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        rst        = 1'b0;
        chk("rst_wins_ready", 128'(ready_w[0]), 128'd1);
        chk("rst_wins_key_addr", 128'(kaddr_w[0]), 128'd0);

        @(posedge clk);
        #1 kseq.delete();
        @(negedge clk);
        p0 = pulse_w[0];
        run_block(0, CT128, -1, res, lat, fbo);
        chk("aes128_out", res, PT);
        chk("aes128_lat", 128'(lat), 128'(lat_exp(10, 1)));
        chk("out_ready_low", 128'(ready_w[0]), 128'd0);
        @(posedge clk);
        @(negedge clk);
        chk("complete_one_cycle", 128'(bc_w[0]), 128'd0);
        chk("ready_back", 128'(ready_w[0]), 128'd1);
        chk("one_pulse", 128'(pulse_w[0] - p0), 128'd1);
        chk("kseq_len", 128'(kseq.size()), 128'd11);
        for (int j = 0; j < 11; j++) begin
            if (j < kseq.size()) chk("kseq", 128'(kseq[j]), 128'(10 - j));
        end
        lat_kl[1] = lat;

        for (int i = 1; i < 4; i++) begin
            run_block(i, CT128, -1, res, lat, fbo);
            chk("sweep_out", res, PT);
            chk("sweep_lat", 128'(lat), 128'(lat_exp(10, KL_T[i])));
            lat_kl[KL_T[i]] = lat;
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 1; k < 4; k++) begin
            chk("lat_step", 128'(lat_kl[k] - lat_kl[k-1]), 128'd11);
        end

        run_block(4, CT192, -1, res, lat, fbo);
        chk("aes192_out", res, PT);
        chk("aes192_lat", 128'(lat), 128'(lat_exp(12, 1)));
        run_block(5, CT256, -1, res, lat, fbo);
        chk("aes256_out", res, PT);
        chk("aes256_lat", 128'(lat), 128'(lat_exp(14, 1)));

        // a second start while busy must be ignored
        @(negedge clk);
        p0 = pulse_w[0];
        run_block(0, CT128, 20, res, lat, fbo);
        chk("busy_out", res, PT);
        chk("busy_lat", 128'(lat), 128'(lat_exp(10, 1)));
        repeat (90) @(posedge clk);
        @(negedge clk);
        chk("busy_no_queue", 128'(pulse_w[0] - p0), 128'd1);
        chk("busy_idle", 128'(ready_w[0]), 128'd1);
        chk("busy_hold", bo_w[0], PT);

        // reset in the middle of round 5
        start_v[0] = 1'b1;
        bin_v[0]   = CT128;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_n = 0;
        while (ridx_w[0] !== 4'd5 && wait_n < 200) begin
            @(posedge clk);
            wait_n++;
            @(negedge clk);
        end
        chk("reach_round5", 128'(wait_n < 200), 128'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        p0  = pulse_w[0];
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 128'(ready_w[0]), 128'd1);
        chk("midrst_block_out", bo_w[0], 128'd0);
        chk("midrst_complete", 128'(bc_w[0]), 128'd0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_pulse", 128'(pulse_w[0] - p0), 128'd0);
        run_block(0, CT128, -1, res, lat, fbo);
        chk("after_rst_out", res, PT);
        chk("after_rst_lat", 128'(lat), 128'(lat_exp(10, 1)));

        // back-to-back: next start in the cycle ready rises
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready", 128'(ready_w[0]), 128'd1);
        chk("b2b_hold", bo_w[0], PT);
        run_block(0, CT128, -1, res, lat, fbo);
        chk("b2b_cleared", fbo, 128'd0);
        chk("b2b_out", res, PT);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("b2b_hold_after", bo_w[0], PT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decipher_core.md
# aes_decipher_core

Iterative AES inverse cipher that takes one 128-bit ciphertext block through the initial AddRoundKey, NR−1 full inverse rounds and one final inverse round. It is the parametrised successor to the single-round decipher block and supports AES-128/192/256 through the round-count parameter `NR`. It reuses the team's `inv_shift_rows`, `inv_sub_bytes`, `add_round_key` and `inv_mix_cols` handshake submodules. Round keys come from an external, already-expanded key-schedule memory with fixed read latency.

## Interface
Parameters:
- `NR`, default 10 — round count; legal values 10, 12, 14 (AES-128/192/256). Any other value is an elaboration error.
- `KEY_LATENCY`, default 1 — cycles from `key_addr` being driven to `round_key_in` being valid; legal range 0..3.

Ports. One clock; reset is synchronous and active-high.
- `clk_in` input 1 — clock.
- `rst_in` input 1 — synchronous, active-high reset.
- `start` input 1 — accept `block_in` when `ready`=1.
- `block_in` input 128 — ciphertext block.
- `key_addr` output 4 — round-key index requested, 0..NR.
- `round_key_in` input 128 — round key, valid `KEY_LATENCY` cycles after `key_addr` is driven.
- `ready` output 1 — high in IDLE only.
- `block_out` output 128 — plaintext; held until the next accepted `start`.
- `block_complete` output 1 — one-cycle pulse when `block_out` updates.
- `round_idx` output 4 — index of the round key currently in use (debug).

## Operation
- States: IDLE, KEY_WAIT, INIT_ARK, ROUND, FINAL, OUTPUT.
- **IDLE**
  - `ready`=1.
  - On `start`: register `block_in` as `state_reg`, set `round_idx`=NR and `key_addr`=NR, load the latency counter with `KEY_LATENCY`, clear `block_out` to 0, then go to KEY_WAIT.
- **KEY_WAIT**
  - Counts down; when the count reaches 0, latch `round_key_in` into `key_reg`.
  - Next state: INIT_ARK when `round_idx`=NR, FINAL when `round_idx`=0, otherwise ROUND.
- **INIT_ARK**
  - `state_reg` ← `state_reg` ^ `key_reg`, done in-block in one cycle.
  - `round_idx`/`key_addr` ← NR−1, then KEY_WAIT.
- **ROUND**
  - Pulse the chain start once: `inv_shift_rows` → `inv_sub_bytes` → `add_round_key`(`key_reg`) → `inv_mix_cols`.
  - On `inv_mix_cols` `valid_out`: `state_reg` ← result, decrement `round_idx`/`key_addr`, then KEY_WAIT.
- **FINAL**
  - Same chain, but the `add_round_key` result is taken directly and `inv_mix_cols` is bypassed.
  - On that `valid_out`: `block_out` ← result, `block_complete`←1, then OUTPUT.
- **OUTPUT**
  - `block_complete`←0, then IDLE.
- Rules:
  - `start` outside IDLE is ignored; no queueing.
  - `key_addr` is stable from the cycle it is driven until the key is latched.
  - Key order is NR, NR−1, …, 1, 0, each index requested exactly once per block.
  - `round_idx` and `key_addr` are 4-bit and never wrap below 0. FINAL is entered only with `round_idx`=0.
  - With `KEY_LATENCY`=0, the key is latched in the same cycle KEY_WAIT is entered, so KEY_WAIT lasts 1 cycle.

## Timing
- Reset values:
  - state IDLE, `ready`=1
  - `block_out`=0, `block_complete`=0
  - `key_addr`=0, `round_idx`=0
  - all submodule starts 0
- Reset mid-operation:
  - Returns to IDLE on the next edge and discards the block.
  - No `block_complete` pulse is produced.
  - Submodules are reset by the same `rst_in`.
- Submodule latency: each submodule has 1-cycle start→`valid_out`, so a full round chain takes 4 cycles and the final chain 3.
- Per-block latency, from the `start` edge to `block_complete` high:
  - L = (NR+1)·(KEY_LATENCY+1) + 1 + (NR−1)·(4+1) + (3+1), where +1 per chain is the start-pulse cycle.
  - A bench measures L once per configuration and requires it to be constant.
- Throughput: the next `start` is accepted at the earliest 2 cycles after the `block_complete` pulse (OUTPUT→IDLE).
- `start` in the same cycle as `rst_in`: reset wins.

## Test plan
- AES-128, `NR`=10, `KEY_LATENCY`=1, keys expanded from 000102…0f:
  - `block_in` 69c4e0d86a7b0430d8cdb78070b4c55a → `block_out` 00112233445566778899aabbccddeeff.
  - One `block_complete` pulse.
  - `key_addr` sequence 10,9,…,0.
- AES-192 and AES-256 with the FIPS-197 C.2/C.3 keys:
  - 192: dda97ca4864cdfe06eaf70a0ec0d7191 → 00112233…eeff.
  - 256: 8ea2b7ca516745bfeafc49904b496089 → 00112233…eeff.
- `KEY_LATENCY` swept over 0..3:
  - Same plaintext for every setting.
  - Latency grows by exactly NR+1 cycles per unit of `KEY_LATENCY`.
- `start` pulsed with a different block while busy:
  - Ignored; the first result is unchanged.
  - The second block is accepted only after `ready` returns.
- `rst_in` asserted in the middle of round 5:
  - Next cycle: `ready`=1, `block_out`=0, no `block_complete`.
  - A fresh block afterwards decrypts correctly.
- Back-to-back blocks started the cycle `ready` rises:
  - Both outputs are correct.
  - `block_out` holds the first result until the second `start`.
